simon_dec_iter: RTL and testbench



---
 rtl/simon_dec_iter.sv | 199 +++++++++++++++++++
 tb/tb_simon_dec_iter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_dec_iter.sv
// Iterative Simon 32/64 decryptor: forward key expansion into a 4-word window, then one inverse round per clock.
// Optional SIMON_KEY_CACHE_EN keeps the last expanded window so a repeated key skips KEYEXP.
module simon_dec_iter #(
    parameter int          N_ROUNDS = 32,
    parameter logic [61:0] Z_SEQ    = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ciphertext,
    input  logic [63:0] keytext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] plaintext,
    output logic        busy
);

    localparam int         KEXP_LEN        = N_ROUNDS - 4;
    localparam logic [4:0] CNT_KEXP_LAST   = 5'(KEXP_LEN - 1);
    localparam logic [4:0] CNT_ROUND_FIRST = 5'(N_ROUNDS - 1);
    localparam logic [15:0] C_CONST        = 16'hfffc;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [15:0] rol1(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

    function automatic logic [15:0] rol2(input logic [15:0] v);
        return {v[13:0], v[15:14]};
    endfunction

    function automatic logic [15:0] rol8(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [15:0] ror1(input logic [15:0] v);
        return {v[0], v[15:1]};
    endfunction

    function automatic logic [15:0] ror3(input logic [15:0] v);
        return {v[2:0], v[15:3]};
    endfunction

    function automatic logic [15:0] round_f(input logic [15:0] v);
        return (rol1(v) & rol8(v)) ^ rol2(v);
    endfunction

    // Z_SEQ is written with z[0] as its leftmost bit.
    function automatic logic zbit(input logic [5:0] idx);
        return Z_SEQ[6'd61 - idx];
    endfunction

    // Shared by both directions: the forward and backward key steps differ only in which word is k0.
    function automatic logic [15:0] key_mix(input logic [15:0] k0, input logic [15:0] k1,
                                            input logic [15:0] k3, input logic z);
        logic [15:0] tmp;
        tmp = ror3(k3) ^ k1;
        return C_CONST ^ {15'b0, z} ^ k0 ^ tmp ^ ror1(tmp);
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_cnt;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_k0;
    logic [15:0] r_k1;
    logic [15:0] r_k2;
    logic [15:0] r_k3;
    logic [31:0] r_pt;

    logic [15:0] w_k_fwd;
    logic [15:0] w_k_bwd;
    logic [15:0] w_y_next;
    logic [5:0]  w_zidx_bwd;
    logic        w_kexp_last;
    logic        w_round_last;
    logic        w_accept;
    logic        w_cache_hit;
    logic [63:0] w_load_win;

    assign w_accept     = (r_state == IDLE) && in_valid;
    assign w_kexp_last  = (r_cnt == CNT_KEXP_LAST);
    assign w_round_last = (r_cnt == 5'd0);

    assign w_k_fwd    = key_mix(r_k0, r_k1, r_k3, zbit({1'b0, r_cnt}));
    // Below cnt=4 the backward key is never consumed, so its Z index is don't-care.
    assign w_zidx_bwd = (r_cnt >= 5'd4) ? ({1'b0, r_cnt} - 6'd4) : 6'd0;
    assign w_k_bwd    = key_mix(r_k3, r_k0, r_k2, zbit(w_zidx_bwd));
    assign w_y_next   = r_x ^ round_f(r_y) ^ r_k3;

`ifdef SIMON_KEY_CACHE_EN
    logic [63:0] r_key;
    logic [63:0] r_cache_key;
    logic [63:0] r_cache_win;
    logic        r_cache_vld;

    assign w_cache_hit = r_cache_vld && (keytext == r_cache_key);
    assign w_load_win  = w_cache_hit ? r_cache_win : keytext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key       <= '0;
            r_cache_key <= '0;
            r_cache_win <= '0;
            r_cache_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key <= keytext;
            end
            if (r_state == KEYEXP && w_kexp_last) begin
                r_cache_key <= r_key;
                r_cache_win <= {w_k_fwd, r_k3, r_k2, r_k1};
                r_cache_vld <= 1'b1;
            end
        end
    end
`else
    assign w_cache_hit = 1'b0;
    assign w_load_win  = keytext;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)     w_state_next = w_cache_hit ? ROUND : KEYEXP;
            KEYEXP:  if (w_kexp_last)  w_state_next = ROUND;
            ROUND:   if (w_round_last) w_state_next = DONE;
            DONE:    if (out_ready)    w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_k0  <= '0;
            r_k1  <= '0;
            r_k2  <= '0;
            r_k3  <= '0;
            r_pt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x <= ciphertext[15:0];
                        r_y <= ciphertext[31:16];
                        {r_k3, r_k2, r_k1, r_k0} <= w_load_win;
                        r_cnt <= w_cache_hit ? CNT_ROUND_FIRST : 5'd0;
                    end
                end
                KEYEXP: begin
                    r_k0  <= r_k1;
                    r_k1  <= r_k2;
                    r_k2  <= r_k3;
                    r_k3  <= w_k_fwd;
                    r_cnt <= w_kexp_last ? CNT_ROUND_FIRST : r_cnt + 5'd1;
                end
                ROUND: begin
                    r_x   <= r_y;
                    r_y   <= w_y_next;
                    r_k3  <= r_k2;
                    r_k2  <= r_k1;
                    r_k1  <= r_k0;
                    r_k0  <= w_k_bwd;
                    r_cnt <= r_cnt - 5'd1;
                    if (w_round_last) begin
                        r_pt <= {r_y, w_y_next};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign plaintext = r_pt;

endmodule

// File: tb/tb_simon_dec_iter.sv
// Bench for simon_dec_iter: array-based Simon 32/64 encryptor model feeds ciphertexts, results checked by assertion.
module tb_simon_dec_iter;

`ifdef SIMON_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ciphertext = '0;
    logic [63:0] keytext = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] plaintext;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    bit          m_vld = 1'b0;
    logic [63:0] m_key = '0;

    logic [61:0] zseq = 62'b11111010001001010110000111001101111101000100101011000011100110;

    simon_dec_iter dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .keytext    (keytext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
        logic [31:0] d;
        d = {v, v} << n;
        return d[31:16];
    endfunction

    function automatic logic [15:0] fm(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] pt, input logic [63:0] key);
        logic [15:0] k [0:31];
        logic [15:0] x, y, tmp;
        for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
        for (int i = 0; i < 28; i++) begin
            tmp = rotl(k[i+3], 13) ^ k[i+1];
            k[i+4] = 16'hfffc ^ {15'b0, zseq[61-i]} ^ k[i] ^ tmp ^ rotl(tmp, 15);
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x = y ^ fm(x) ^ k[i];
            y = tmp;
        end
        return {y, x};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick;
        rst = 1'b0;
        m_vld = 1'b0;
    endtask

    task automatic accept(input logic [31:0] ct, input logic [63:0] key, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            tick;
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        lat = (CACHE_EN && m_vld && key == m_key) ? 32 : 60;
        if (lat == 60) begin
            m_vld = 1'b1;
            m_key = key;
        end
        in_valid   = 1'b1;
        ciphertext = ct;
        keytext    = key;
        tick;
        in_valid   = 1'b0;
    endtask

    task automatic collect(input logic [31:0] exp_pt, input int exp_lat, input int already,
                           input string tag);
        int e;
        e = already;
        while (!out_valid && e < exp_lat + 20) begin
            tick;
            e++;
        end
        chk({tag, "_latency"}, e, exp_lat);
        chk({tag, "_pt"}, plaintext, exp_pt);
        out_ready = 1'b1;
        tick;
        chk({tag, "_ov_drop"}, out_valid, 0);
        chk({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] KAT_CT  = 32'he9bb_c69b;
    localparam logic [31:0] KAT_PT  = 32'h6565_6877;

    initial begin
        int lat;
        logic [31:0] held_pt;
        logic [31:0] pt;
        logic [63:0] key;

        do_reset(3);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_plaintext", plaintext, 0);
        chk("rst_busy", busy, 0);

        accept(KAT_CT, KAT_KEY, lat);
        chk("kat_busy", busy, 1);
        chk("kat_in_ready_busy", in_ready, 0);
        collect(KAT_PT, lat, 0, "kat");

        // Backpressure
        out_ready = 1'b0;
        accept(KAT_CT, KAT_KEY, lat);
        for (int e = 0; e < lat + 20 && !out_valid; e++) tick;
        chk("bp_ov_rise", out_valid, 1);
        held_pt = plaintext;
        chk("bp_pt", held_pt, KAT_PT);
        for (int c = 0; c < 10; c++) begin
            tick;
            chk("bp_ov_hold", out_valid, 1);
            chk("bp_pt_hold", plaintext, KAT_PT);
            chk("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        chk("bp_release_ov", out_valid, 0);
        chk("bp_release_in_ready", in_ready, 1);

        // Input offered while in ROUND is ignored
        accept(KAT_CT, KAT_KEY, lat);
        repeat (lat - 32 + 5) tick;
        in_valid   = 1'b1;
        ciphertext = 32'h1234_5678;
        keytext    = 64'hdead_beef_cafe_f00d;
        chk("busy_in_ready_low", in_ready, 0);
        tick;
        chk("busy_in_ready_low2", in_ready, 0);
        in_valid = 1'b0;
        collect(KAT_PT, lat, lat - 32 + 6, "busy_ignore");

        // Reset while ROUND cnt=15
        accept(KAT_CT, KAT_KEY, lat);
        repeat (lat - 32 + 16) tick;
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_vld = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_pt", plaintext, 0);
        accept(KAT_CT, KAT_KEY, lat);
        collect(KAT_PT, lat, 0, "kat_after_rst");

        // Key cache: repeated key then a new key
        key = {$urandom, $urandom};
        pt  = $urandom;
        accept(encrypt(pt, key), key, lat);
        collect(pt, lat, 0, "cache_first");
        pt = $urandom;
        accept(encrypt(pt, key), key, lat);
        chk("cache_second_lat_model", lat, CACHE_EN ? 32 : 60);
        collect(pt, lat, 0, "cache_second");
        key = ~key;
        pt  = $urandom;
        accept(encrypt(pt, key), key, lat);
        chk("cache_newkey_lat_model", lat, 60);
        collect(pt, lat, 0, "cache_newkey");

        // Round trip with random and extreme vectors
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) begin
                key = '0;
                pt  = '0;
            end else if (i == 1) begin
                key = '1;
                pt  = '1;
            end else begin
                key = {$urandom, $urandom};
                pt  = $urandom;
            end
            accept(encrypt(pt, key), key, lat);
            collect(pt, lat, 0, "roundtrip");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
